// File: rtl/mef1_reservatorio_if.sv
// ---------------------------------------------------------------------------
// mef1_reservatorio_if
// Bundle of sensor inputs and valve/status outputs of the reservoir FSM.
//   s_baixo/s_medio/s_alto : tank level marks (low/middle/high)
//   seco                   : raw soil-dry sensor
//   limpeza                : cleaning request (level)
//   erro_rega              : error flag from the irrigation validator
//   mef1                   : 2-bit state code
//   VE / VS                : fill / drain valves
//   erro_nivel             : level-sensor inconsistency flag
// master = environment side, slave = reservoir FSM side.
// ---------------------------------------------------------------------------
interface mef1_reservatorio_if;
   logic       s_baixo;
   logic       s_medio;
   logic       s_alto;
   logic       seco;
   logic       limpeza;
   logic       erro_rega;
   logic [1:0] mef1;
   logic       VE;
   logic       VS;
   logic       erro_nivel;

   modport master (
      output s_baixo, s_medio, s_alto, seco, limpeza, erro_rega,
      input  mef1, VE, VS, erro_nivel
   );

   modport slave (
      input  s_baixo, s_medio, s_alto, seco, limpeza, erro_rega,
      output mef1, VE, VS, erro_nivel
   );
endinterface

// File: rtl/mef1_reservatorio.sv
// ---------------------------------------------------------------------------
// mef1_reservatorio
// Reservoir manager FSM (MEF1): fills the tank, runs timed drain/cleaning
// cycles, debounces the soil-dry sensor and hands the REGA state to the
// irrigation validator through the mef1 code.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of mef1_reservatorio_if (sensors in, valves out)
// All outputs are registered; they reflect inputs sampled one edge earlier.
// ---------------------------------------------------------------------------
module mef1_reservatorio #(
   parameter int DEB_CICLOS  = 16,
   parameter int LIMP_CICLOS = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mef1_reservatorio_if.slave    bus
);

   localparam int DW = (DEB_CICLOS  > 1) ? $clog2(DEB_CICLOS)  : 1;
   localparam int LW = (LIMP_CICLOS > 1) ? $clog2(LIMP_CICLOS) : 1;
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CICLOS - 1);
   localparam logic [LW-1:0] LIMP_MAX = LW'(LIMP_CICLOS - 1);

   typedef enum logic [1:0] {
      ESPERA   = 2'b00,
      ENCHENDO = 2'b01,
      LIMPEZA  = 2'b10,
      REGA     = 2'b11
   } estado_t;

   estado_t       r_estado;
   estado_t       w_prox;
   logic          r_seco_filt;
   logic [DW-1:0] r_deb_cnt;
   logic [LW-1:0] r_limp_cnt;
   logic          r_ve;
   logic          r_vs;
   logic          r_erro_nivel;
   logic          w_incons;

   // Water can only sit above a mark if it is above every lower mark.
   assign w_incons = (bus.s_alto & ~bus.s_medio) | (bus.s_medio & ~bus.s_baixo);

   always_comb begin
      w_prox = r_estado;
      if (w_incons)
         w_prox = ESPERA;
      else if (bus.limpeza && r_estado != LIMPEZA)
         w_prox = LIMPEZA;
      else begin
         unique case (r_estado)
            ESPERA: begin
               if (!bus.s_baixo)     w_prox = ENCHENDO;
               else if (r_seco_filt) w_prox = REGA;
            end
            ENCHENDO: begin
               if (bus.s_alto) w_prox = ESPERA;
            end
            LIMPEZA: begin
               // Drain until empty, but never leave before the minimum dwell.
               if (r_limp_cnt == LIMP_MAX && !bus.s_baixo) w_prox = ENCHENDO;
            end
            REGA: begin
               if (bus.erro_rega)     w_prox = ESPERA;
               else if (!bus.s_baixo) w_prox = ENCHENDO;
               else if (!r_seco_filt) w_prox = ESPERA;
            end
            default: w_prox = ESPERA;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_estado     <= ESPERA;
         r_ve         <= 1'b0;
         r_vs         <= 1'b0;
         r_erro_nivel <= 1'b0;
         r_seco_filt  <= 1'b0;
         r_deb_cnt    <= '0;
         r_limp_cnt   <= '0;
      end else begin
         r_estado     <= w_prox;
         r_ve         <= (w_prox == ENCHENDO);
         r_vs         <= (w_prox == LIMPEZA);
         r_erro_nivel <= w_incons;

         // Debounce: filtered value flips only after a sustained disagreement.
         if (bus.seco == r_seco_filt)
            r_deb_cnt <= '0;
         else if (r_deb_cnt == DEB_MAX) begin
            r_seco_filt <= ~r_seco_filt;
            r_deb_cnt   <= '0;
         end else
            r_deb_cnt <= r_deb_cnt + 1'b1;

         // Cleaning timer runs only while in LIMPEZA and saturates.
         if (r_estado != LIMPEZA)
            r_limp_cnt <= '0;
         else if (r_limp_cnt != LIMP_MAX)
            r_limp_cnt <= r_limp_cnt + 1'b1;
      end
   end

   assign bus.mef1       = r_estado;
   assign bus.VE         = r_ve;
   assign bus.VS         = r_vs;
   assign bus.erro_nivel = r_erro_nivel;

endmodule

// File: tb/tb_mef1_reservatorio.sv
// ---------------------------------------------------------------------------
// tb_mef1_reservatorio
// Directed test of mef1_reservatorio with DEB_CICLOS=4, LIMP_CICLOS=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_mef1_reservatorio;
   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   mef1_reservatorio_if bus ();

   mef1_reservatorio #(.DEB_CICLOS(4), .LIMP_CICLOS(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // (s_alto, s_medio, s_baixo)
   task automatic lvl(input logic [2:0] v);
      {bus.s_alto, bus.s_medio, bus.s_baixo} = v;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset_n       = 1'b0;
      bus.seco      = 1'b0;
      bus.limpeza   = 1'b0;
      bus.erro_rega = 1'b0;
      lvl(3'b000);
      #13;
      chk("rst_mef1", bus.mef1, 2'b00);
      chk("rst_VE", bus.VE, 1'b0);
      chk("rst_VS", bus.VS, 1'b0);
      chk("rst_erro", bus.erro_nivel, 1'b0);
      tick();
      reset_n = 1'b1;

      // Empty tank -> fill, full -> wait
      tick();
      chk("fill_mef1", bus.mef1, 2'b01);
      chk("fill_VE", bus.VE, 1'b1);
      lvl(3'b111);
      tick();
      chk("full_mef1", bus.mef1, 2'b00);
      chk("full_VE", bus.VE, 1'b0);

      // Debounced dry sensor -> REGA after 4 edges + 1
      lvl(3'b011);
      bus.seco = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("deb_wait%0d", i), bus.mef1, 2'b00);
      end
      tick();
      chk("rega_enter", bus.mef1, 2'b11);

      // Validator error leaves REGA
      bus.erro_rega = 1'b1;
      tick();
      chk("erro_rega", bus.mef1, 2'b00);
      bus.erro_rega = 1'b0;
      tick();
      chk("rega_again", bus.mef1, 2'b11);
      lvl(3'b000);
      tick();
      chk("rega_empty", bus.mef1, 2'b01);
      chk("rega_empty_VE", bus.VE, 1'b1);

      // Let filtered seco fall while filling, then a 3-cycle glitch
      bus.seco = 1'b0;
      repeat (5) tick();
      chk("fill_hold", bus.mef1, 2'b01);
      lvl(3'b111);
      tick();
      lvl(3'b011);
      tick();
      chk("pre_glitch", bus.mef1, 2'b00);
      bus.seco = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("glitch_hi%0d", i), bus.mef1, 2'b00);
      end
      bus.seco = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("glitch_lo%0d", i), bus.mef1, 2'b00);
      end

      // Cleaning request aborts filling; stays while tank not empty
      lvl(3'b000);
      tick();
      chk("fill2", bus.mef1, 2'b01);
      bus.limpeza = 1'b1;
      tick();
      bus.limpeza = 1'b0;
      chk("limp_mef1", bus.mef1, 2'b10);
      chk("limp_VS", bus.VS, 1'b1);
      chk("limp_VE", bus.VE, 1'b0);
      lvl(3'b011);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("limp_hold%0d", i), bus.mef1, 2'b10);
      end
      lvl(3'b000);
      tick();
      chk("limp_exit", bus.mef1, 2'b01);
      chk("limp_exit_VS", bus.VS, 1'b0);

      // Empty tank: LIMPEZA lasts exactly 8 cycles
      bus.limpeza = 1'b1;
      tick();
      bus.limpeza = 1'b0;
      chk("dwell0", bus.mef1, 2'b10);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("dwell%0d", i), bus.mef1, 2'b10);
      end
      tick();
      chk("dwell_end", bus.mef1, 2'b01);

      // Inconsistent levels win over everything
      lvl(3'b101);
      tick();
      chk("inc_erro", bus.erro_nivel, 1'b1);
      chk("inc_mef1", bus.mef1, 2'b00);
      bus.limpeza = 1'b1;
      tick();
      chk("inc_limp_mef1", bus.mef1, 2'b00);
      chk("inc_limp_erro", bus.erro_nivel, 1'b1);
      bus.limpeza = 1'b0;
      lvl(3'b001);
      tick();
      chk("rec_erro", bus.erro_nivel, 1'b0);
      chk("rec_mef1", bus.mef1, 2'b00);
      lvl(3'b000);
      tick();
      chk("rec_fill", bus.mef1, 2'b01);

      // Async reset in the middle of LIMPEZA
      lvl(3'b001);
      bus.limpeza = 1'b1;
      tick();
      bus.limpeza = 1'b0;
      chk("pre_rst_limp", bus.mef1, 2'b10);
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_mef1", bus.mef1, 2'b00);
      chk("arst_VS", bus.VS, 1'b0);
      #1;
      reset_n = 1'b1;
      tick();
      chk("post_rst", bus.mef1, 2'b00);
      lvl(3'b000);
      bus.limpeza = 1'b1;
      tick();
      bus.limpeza = 1'b0;
      chk("rlimp0", bus.mef1, 2'b10);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("rlimp%0d", i), bus.mef1, 2'b10);
      end
      tick();
      chk("rlimp_end", bus.mef1, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
